// File: rtl/fma_dot_sequencer_if.sv
// Command, operand, FMA-pin and result signal bundle for fma_dot_sequencer.
// The slave modport is the sequencer's view; the master modport is the issuer/FMA/consumer side.
interface fma_dot_sequencer_if #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 8
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [LEN_W-1:0]     cmd_len;
    logic [WIDTH-1:0]     cmd_bias;

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;

    logic [3*WIDTH-1:0]   fma_abc;
    logic                 fma_valid;
    logic                 fma_c_valid;
    logic                 fma_out_en;
    logic [WIDTH-1:0]     fma_out;
    logic                 fma_valid_out;

    logic                 result_valid;
    logic                 result_ready;
    logic [WIDTH-1:0]     result_data;

    logic                 busy;
    logic [15:0]          stall_cycles;

    modport slave (
        input  cmd_valid, cmd_len, cmd_bias,
        input  in_valid, in_a, in_b,
        input  fma_out, fma_valid_out,
        input  result_ready,
        output cmd_ready, in_ready,
        output fma_abc, fma_valid, fma_c_valid, fma_out_en,
        output result_valid, result_data,
        output busy, stall_cycles
    );

    modport master (
        output cmd_valid, cmd_len, cmd_bias,
        output in_valid, in_a, in_b,
        output fma_out, fma_valid_out,
        output result_ready,
        input  cmd_ready, in_ready,
        input  fma_abc, fma_valid, fma_c_valid, fma_out_en,
        input  result_valid, result_data,
        input  busy, stall_cycles
    );
endinterface

// File: rtl/fma_dot_sequencer.sv
// Sequences one FMA lane through bias + sum(a[i]*b[i]); one registered result per command.
// Latency: last operand transfer at t -> fma_valid t+1, result_valid t+3. Backpressure: in_ready only in RUN, result held until result_ready.
// Optional FMA_SEQ_STALL_CNT_EN adds a saturating count of RUN cycles with no operand offered.
module fma_dot_sequencer #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    fma_dot_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic [LEN_W-1:0]     r_remaining;
    logic                 r_first;
    logic [WIDTH-1:0]     r_bias;
    logic [WIDTH-1:0]     r_result;
    logic [3*WIDTH-1:0]   r_fma_abc;
    logic                 r_fma_valid;
    logic                 r_fma_c_valid;
    logic                 r_fma_out_en;

    logic                 w_cmd_fire;
    logic                 w_in_fire;
    logic                 w_res_fire;
    logic                 w_last;

    assign w_cmd_fire = bus.cmd_valid && (r_state == S_IDLE);
    assign w_in_fire  = bus.in_valid && (r_state == S_RUN);
    assign w_res_fire = bus.result_ready && (r_state == S_DONE);
    assign w_last     = (r_remaining == LEN_W'(1));

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_cmd_fire) w_next = (bus.cmd_len == '0) ? S_DONE : S_RUN;
            S_RUN:  if (w_in_fire && w_last) w_next = S_WAIT;
            S_WAIT: if (bus.fma_valid_out) w_next = S_DONE;
            S_DONE: if (w_res_fire) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // FMA pins are registered one cycle behind the operand transfer they carry.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_remaining   <= '0;
            r_first       <= 1'b0;
            r_bias        <= '0;
            r_result      <= '0;
            r_fma_abc     <= '0;
            r_fma_valid   <= 1'b0;
            r_fma_c_valid <= 1'b0;
            r_fma_out_en  <= 1'b0;
        end else begin
            r_fma_valid   <= w_in_fire;
            r_fma_c_valid <= w_in_fire && r_first;
            r_fma_out_en  <= w_in_fire && w_last;

            if (w_cmd_fire) begin
                r_bias      <= bus.cmd_bias;
                r_remaining <= bus.cmd_len;
                r_first     <= 1'b1;
                if (bus.cmd_len == '0) begin
                    r_result <= bus.cmd_bias;
                end
            end

            if (w_in_fire) begin
                r_fma_abc   <= {bus.in_a, bus.in_b, (r_first ? r_bias : {WIDTH{1'b0}})};
                r_remaining <= r_remaining - LEN_W'(1);
                r_first     <= 1'b0;
            end

            if ((r_state == S_WAIT) && bus.fma_valid_out) begin
                r_result <= bus.fma_out;
            end
        end
    end

    assign bus.cmd_ready    = (r_state == S_IDLE);
    assign bus.in_ready     = (r_state == S_RUN);
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.result_valid = (r_state == S_DONE);
    assign bus.result_data  = r_result;
    assign bus.fma_abc      = r_fma_abc;
    assign bus.fma_valid    = r_fma_valid;
    assign bus.fma_c_valid  = r_fma_c_valid;
    assign bus.fma_out_en   = r_fma_out_en;

`ifdef FMA_SEQ_STALL_CNT_EN
    logic [15:0] r_stall_cycles;

    // Holds through WAIT/DONE/IDLE so software can read it after the result.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_stall_cycles <= '0;
        end else if (w_cmd_fire) begin
            r_stall_cycles <= '0;
        end else if ((r_state == S_RUN) && !bus.in_valid && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign bus.stall_cycles = r_stall_cycles;
`else
    assign bus.stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_fma_dot_sequencer.sv
// Directed bench for fma_dot_sequencer with a behavioural Q-format FMA (FIXED_POINT=10) attached.
module tb_fma_dot_sequencer;

    localparam int WIDTH = 16;
    localparam int LEN_W = 8;
    localparam int FIXED_POINT = 10;

    logic clk;
    logic rst;

    fma_dot_sequencer_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

    fma_dot_sequencer #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural FMA: acc = (c_valid ? c : acc) + (a*b >>> FIXED_POINT), one cycle latency.
    logic signed [WIDTH-1:0]   fm_acc;
    logic                      fm_vout;
    logic signed [2*WIDTH-1:0] w_prod;
    logic signed [WIDTH-1:0]   w_base;
    logic signed [WIDTH-1:0]   w_term;

    always_comb begin
        w_prod = $signed(bus.fma_abc[3*WIDTH-1:2*WIDTH]) * $signed(bus.fma_abc[2*WIDTH-1:WIDTH]);
        w_term = WIDTH'(w_prod >>> FIXED_POINT);
        w_base = bus.fma_c_valid ? $signed(bus.fma_abc[WIDTH-1:0]) : fm_acc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fm_acc  <= '0;
            fm_vout <= 1'b0;
        end else begin
            fm_vout <= bus.fma_valid && bus.fma_out_en;
            if (bus.fma_valid) fm_acc <= w_base + w_term;
        end
    end

    assign bus.fma_out       = fm_acc;
    assign bus.fma_valid_out = fm_vout;

    int          n_total = 0;
    int          n_bad   = 0;
    int          cyc     = 0;
    int          hs_cyc  = 0;
    int          rv_cyc  = 0;
    int          n_fv    = 0;
    logic [31:0] cv_mask;
    logic [31:0] oe_mask;
    logic [47:0] first_abc;
    logic [15:0] va [8];
    logic [15:0] vb [8];
    logic [15:0] held;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        n_fv      = 0;
        cv_mask   = '0;
        oe_mask   = '0;
        first_abc = '0;
    endtask

    // Advance to the next falling edge and record the FMA-side pins seen there.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (bus.fma_valid) begin
            if (n_fv == 0) first_abc = bus.fma_abc;
            if (bus.fma_c_valid) cv_mask |= (32'd1 << n_fv);
            if (bus.fma_out_en)  oe_mask |= (32'd1 << n_fv);
            n_fv++;
        end
    endtask

    task automatic send_cmd(input logic [7:0] len, input logic [15:0] bias);
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = len;
        bus.cmd_bias  = bias;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic push(input int n, input bit gaps);
        int i = 0;
        int guard = 0;
        bit phase = 1'b0;
        while (i < n && guard < 200) begin
            if (gaps && phase) begin
                bus.in_valid = 1'b0;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_a     = va[i];
                bus.in_b     = vb[i];
            end
            phase = !phase;
            if (bus.in_valid && bus.in_ready) begin
                i++;
                hs_cyc = cyc;
            end
            tick();
            guard++;
        end
        bus.in_valid = 1'b0;
        chk("push_count", i, n);
    endtask

    task automatic wait_result();
        int g = 0;
        while (!bus.result_valid && g < 50) begin
            tick();
            g++;
        end
        rv_cyc = cyc;
        chk("result_arrives", bus.result_valid, 1'b1);
    endtask

    task automatic ack_result();
        bus.result_ready = 1'b1;
        chk("cmd_ready_in_hs", bus.cmd_ready, 1'b0);
        tick();
        bus.result_ready = 1'b0;
        chk("cmd_ready_after_hs", bus.cmd_ready, 1'b1);
        chk("result_valid_after_hs", bus.result_valid, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst              = 1'b1;
        bus.cmd_valid    = 1'b0;
        bus.cmd_len      = '0;
        bus.cmd_bias     = '0;
        bus.in_valid     = 1'b0;
        bus.in_a         = '0;
        bus.in_b         = '0;
        bus.result_ready = 1'b0;
        clear_mon();

        tick();
        tick();
        chk("rst_cmd_ready", bus.cmd_ready, 1'b1);
        chk("rst_outputs", {bus.in_ready, bus.busy, bus.result_valid, bus.fma_valid,
                            bus.fma_c_valid, bus.fma_out_en}, 6'b0);
        chk("rst_abc", bus.fma_abc, 48'h0);
        chk("rst_result", bus.result_data, 16'h0);
        chk("rst_stall", bus.stall_cycles, 16'h0);
        rst = 1'b0;
        tick();

        // Three-element dot product, operands streamed back to back.
        va[0] = 16'd1024; vb[0] = 16'd1024;
        va[1] = 16'd2048; vb[1] = 16'd1024;
        va[2] = 16'd3072; vb[2] = 16'd512;
        clear_mon();
        send_cmd(8'd3, 16'd512);
        chk("t1_busy", bus.busy, 1'b1);
        push(3, 1'b0);
        wait_result();
        chk("t1_result", bus.result_data, 16'd5120);
        chk("t1_latency", rv_cyc - hs_cyc, 3);
        chk("t1_fma_pulses", n_fv, 3);
        chk("t1_c_valid_pos", cv_mask, 32'h1);
        chk("t1_out_en_pos", oe_mask, 32'h4);
        chk("t1_first_abc", first_abc, 48'h0400_0400_0200);
        chk("t1_stall", bus.stall_cycles, 16'd0);
        ack_result();

        // Zero-length command returns the bias without touching the FMA.
        clear_mon();
        send_cmd(8'd0, 16'h1234);
        chk("t2_result_valid", bus.result_valid, 1'b1);
        chk("t2_result", bus.result_data, 16'h1234);
        tick();
        chk("t2_fma_pulses", n_fv, 0);
        ack_result();

        // Gapped operand stream and a slow result consumer.
        va[0] = 16'd1024; vb[0] = 16'd1024;
        va[1] = 16'd1024; vb[1] = 16'd2048;
        va[2] = 16'd1024; vb[2] = 16'd512;
        va[3] = 16'd1024; vb[3] = 16'd1024;
        clear_mon();
        send_cmd(8'd4, 16'd0);
        push(4, 1'b1);
        wait_result();
        chk("t3_fma_pulses", n_fv, 4);
        chk("t3_c_valid_pos", cv_mask, 32'h1);
        chk("t3_out_en_pos", oe_mask, 32'h8);
        held = bus.result_data;
        chk("t3_result", held, 16'd4608);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t3_hold_data", bus.result_data, 16'd4608);
            chk("t3_hold_cmd_ready", bus.cmd_ready, 1'b0);
        end
`ifdef FMA_SEQ_STALL_CNT_EN
        chk("t3_stall", bus.stall_cycles, 16'd3);
`else
        chk("t3_stall", bus.stall_cycles, 16'd0);
`endif
        ack_result();

        // Asynchronous reset in the middle of an eight-element command.
        for (int k = 0; k < 8; k++) begin
            va[k] = 16'd1024;
            vb[k] = 16'd1024;
        end
        clear_mon();
        send_cmd(8'd8, 16'd0);
        push(3, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("t4_rst_cmd_ready", bus.cmd_ready, 1'b1);
        chk("t4_rst_outputs", {bus.in_ready, bus.busy, bus.result_valid, bus.fma_valid,
                               bus.fma_c_valid, bus.fma_out_en}, 6'b0);
        chk("t4_rst_abc", bus.fma_abc, 48'h0);
        #1;
        rst = 1'b0;
        tick();
        clear_mon();
        send_cmd(8'd1, 16'd0);
        push(1, 1'b0);
        wait_result();
        chk("t4_result", bus.result_data, 16'd1024);
        chk("t4_c_valid_pos", cv_mask, 32'h1);
        chk("t4_out_en_pos", oe_mask, 32'h1);
        ack_result();

        // Stall counting: five idle RUN cycles before the operands arrive.
        va[0] = 16'd1024; vb[0] = 16'd1024;
        va[1] = 16'd1024; vb[1] = 16'd1024;
        clear_mon();
        send_cmd(8'd2, 16'd0);
        for (int k = 0; k < 5; k++) tick();
        push(2, 1'b0);
        wait_result();
        chk("t5_result", bus.result_data, 16'd2048);
`ifdef FMA_SEQ_STALL_CNT_EN
        chk("t5_stall", bus.stall_cycles, 16'd5);
`else
        chk("t5_stall", bus.stall_cycles, 16'd0);
`endif
        ack_result();
        send_cmd(8'd0, 16'h0001);
        chk("t5_stall_clear", bus.stall_cycles, 16'd0);
        ack_result();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/fma_dot_sequencer.md
Name: fma_dot_sequencer

Overview:
- Sequences a single `fma` lane through an N-element dot product with bias: out = bias + sum(a[i]*b[i]).
- Accepts one command at a time and pulls operand pairs over a valid/ready stream.
- Drives the FMA's abc/valid/c_valid/output-enable pins and returns one registered result per command.
- Sits between the operand buffer / command issuer and one FMA instance.

Parameters:
- WIDTH, 16, bits per fixed-point operand/result; must match the attached FMA.
- LEN_W, 8, width of the element-count field; maximum N = 2^LEN_W - 1.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  reset; asynchronous, active-high
- cmd_valid  input  1  command offered
- cmd_ready  output  1  high only in IDLE
- cmd_len  input  LEN_W  element count N
- cmd_bias  input  WIDTH  c term, added once
- in_valid  input  1  operand pair offered
- in_ready  output  1  high only in RUN
- in_a  input  WIDTH  operand a
- in_b  input  WIDTH  operand b
- fma_abc  output  3*WIDTH  {a, b, c} to FMA
- fma_valid  output  1  to FMA valid_in
- fma_c_valid  output  1  to FMA c_valid_in
- fma_out_en  output  1  to FMA output_can_be_valid_in
- fma_out  input  WIDTH  FMA out
- fma_valid_out  input  1  FMA valid_out
- result_valid  output  1  result held
- result_ready  input  1  result consumed
- result_data  output  WIDTH  dot-product result
- busy  output  1  state != IDLE
- stall_cycles  output  16  see Optional Feature

Behaviour:
- Reset (async, any state): state=IDLE.
  - All outputs 0, except cmd_ready=1.
  - Remaining counter, first flag and captured result cleared.
  - An in-flight command is discarded, with no partial result.
- States: IDLE, RUN, WAIT, DONE.
- IDLE:
  - cmd_valid&&cmd_ready latches len and bias.
  - If len==0: go to DONE next cycle with result_data=cmd_bias; the FMA is untouched.
  - Otherwise go to RUN with remaining=len and first=1.
- RUN:
  - Transfer = in_valid&&in_ready.
  - Per transfer, next cycle (registered FMA-side outputs):
    - fma_valid=1
    - fma_abc={in_a, in_b, first ? bias : 0}
    - fma_c_valid=first
    - fma_out_en=(remaining==1)
  - After each transfer, remaining decrements and first clears.
  - Cycles with no transfer drive fma_valid=0, fma_c_valid=0 and fma_out_en=0; the FMA holds its accumulator.
  - The transfer with remaining==1 moves the block to WAIT.
- WAIT:
  - On fma_valid_out, capture fma_out into result_data and go to DONE.
  - fma_valid_out in any other state is ignored.
- DONE:
  - result_valid=1; result_data stable until result_ready.
  - On the handshake, go to IDLE next cycle. No command is accepted in the handshake cycle.
- Latency, last transfer at cycle t:
  - fma_valid at t+1
  - fma_valid_out at t+2
  - result_valid at t+3
- A single-element command is legal: that element has fma_c_valid=1 and fma_out_en=1 together.
- Arithmetic: the sequencer does no math; fixed-point width and truncation are the FMA's.
- Overflow of N beyond 2^LEN_W-1 is impossible by construction.

Optional Feature:
- FMA_SEQ_STALL_CNT_EN
- Defined:
  - stall_cycles counts RUN cycles with in_valid=0.
  - The count saturates at 16'hFFFF.
  - It clears when a command is accepted.
  - It holds its value through WAIT/DONE/IDLE until the next accept.
- Undefined: stall_cycles is tied to 0 and no counter logic is generated.

Test Plan:
- Dot product with the FMA attached (WIDTH=16, FIXED_POINT=10):
  - Stimulus: N=3, a={1024,2048,3072}, b={1024,1024,512}, bias=512, in_valid held high.
  - Response: result_data=5120, result_valid 3 cycles after the last in handshake, fma_c_valid only on element 0, fma_out_en only on element 2.
- len==0, bias=0x1234 -> result_valid=1 next cycle with result_data=0x1234; fma_valid never asserts.
- Back-pressure:
  - Stimulus: N=4, in_valid toggling 1,0,1,0,...; result_ready low for 5 cycles.
  - Response: exactly 4 fma_valid pulses; result_data stable while result_ready is low; cmd_ready stays 0 until the cycle after the handshake.
- Async reset mid-RUN:
  - Stimulus: N=8, rst_in pulsed after 3 transfers (between clock edges).
  - Response: outputs 0 and cmd_ready=1 immediately; a following N=1 command (a=b=1024, bias=0) returns 1024.
- Stall counter, FMA_SEQ_STALL_CNT_EN defined:
  - Stimulus: N=2 with 5 idle RUN cycles.
  - Response: stall_cycles=5; it resets to 0 on the next cmd accept.
- Stall counter, macro undefined: stall_cycles=0 throughout.
